// File: rtl/mul_share_ctrl_if.sv
// rtl/mul_share_ctrl_if.sv - requester and datapath signal bundle for the shared multiplier sequencer
interface mul_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic              result_valid;
    logic [IDW-1:0]    result_id;
    logic              busy;
    logic [W-1:0]      dp_bus;
    logic              dp_lda;
    logic              dp_ldb;
    logic              dp_ldp;
    logic              dp_clrp;
    logic              dp_decb;
    logic              dp_eqz;
    logic [W-1:0]      dp_prod;

    modport slave (
        input  req, op_a, op_b, dp_eqz, dp_prod,
        output ack, result, result_valid, result_id, busy,
               dp_bus, dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb
    );

    modport master (
        output req, op_a, op_b, dp_eqz, dp_prod,
        input  ack, result, result_valid, result_id, busy,
               dp_bus, dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sequencer sharing one repeated-addition multiplier datapath
module mul_share_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    mul_share_ctrl_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, LOADA, LOADB, ACC, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  gnt_sel;
    logic            gnt_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [W-1:0]    res_q;
    logic [IDW-1:0]  res_id_q;
    int              idx;

    logic [NREQ-1:0] ack;
    logic            result_valid;
    logic            busy;
    logic [W-1:0]    dp_bus;
    logic            dp_lda;
    logic            dp_ldb;
    logic            dp_ldp;
    logic            dp_clrp;
    logic            dp_decb;

    // Scan downward so the lowest offset from rr_ptr is the final winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = '0;
        idx     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[idx[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_sel = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_sel == IDW'(i)) begin
                sel_a = bus.op_a[i*W +: W];
                sel_b = bus.op_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            hi       <= '0;
            lo       <= '0;
            res_q    <= '0;
            res_id_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gnt_id <= gnt_sel;
                        // Larger operand goes to A so the loop runs min(a,b) times.
                        hi     <= (sel_a >= sel_b) ? sel_a : sel_b;
                        lo     <= (sel_a >= sel_b) ? sel_b : sel_a;
                        rr_ptr <= (gnt_sel == IDW'(NREQ - 1)) ? '0 : gnt_sel + 1'b1;
                    end
                end
                ACC: begin
                    if (bus.dp_eqz) begin
                        res_q    <= bus.dp_prod;
                        res_id_q <= gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        ack          = '0;
        result_valid = 1'b0;
        busy         = 1'b1;
        dp_bus       = '0;
        dp_lda       = 1'b0;
        dp_ldb       = 1'b0;
        dp_ldp       = 1'b0;
        dp_clrp      = 1'b0;
        dp_decb      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (gnt_any) state_nxt = LOADA;
            end
            LOADA: begin
                dp_bus    = hi;
                dp_lda    = 1'b1;
                state_nxt = LOADB;
            end
            LOADB: begin
                dp_bus    = lo;
                dp_ldb    = 1'b1;
                dp_clrp   = 1'b1;
                state_nxt = ACC;
            end
            ACC: begin
                if (!bus.dp_eqz) begin
                    dp_ldp  = 1'b1;
                    dp_decb = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack[gnt_id]  = 1'b1;
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ack          = ack;
    assign bus.result       = res_q;
    assign bus.result_valid = result_valid;
    assign bus.result_id    = res_id_q;
    assign bus.busy         = busy;
    assign bus.dp_bus       = dp_bus;
    assign bus.dp_lda       = dp_lda;
    assign bus.dp_ldb       = dp_ldb;
    assign bus.dp_ldp       = dp_ldp;
    assign bus.dp_clrp      = dp_clrp;
    assign bus.dp_decb      = dp_decb;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl with a behavioural datapath
module tb_mul_share_ctrl;
    localparam int NREQ = 4;
    localparam int W    = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_ptr = 0;

    mul_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

    mul_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [W-1:0] dpa = '0;
    logic [W-1:0] dpb = '0;
    logic [W-1:0] dpp = '0;

    always @(posedge clock) begin
        if (bus.dp_lda) dpa <= bus.dp_bus;
        if (bus.dp_ldb) dpb <= bus.dp_bus;
        else if (bus.dp_decb) dpb <= dpb - 1'b1;
        if (bus.dp_clrp) dpp <= '0;
        else if (bus.dp_ldp) dpp <= dpp + dpa;
    end

    assign bus.dp_eqz  = (dpb == '0);
    assign bus.dp_prod = dpp;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_prod(input longint a, input longint b);
        return (a * b) % 65536;
    endfunction

    function automatic int ref_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [5:0] strobes();
        return {bus.busy, bus.dp_lda, bus.dp_ldb, bus.dp_ldp, bus.dp_clrp, bus.dp_decb};
    endfunction

    task automatic wait_ack(input int bound, output bit ok, output int lat, output int ldps);
        ok = 1'b0;
        lat = 0;
        ldps = 0;
        while (!ok && lat < bound) begin
            @(negedge clock);
            lat++;
            if (bus.dp_ldp) ldps++;
            if (bus.result_valid) ok = 1'b1;
        end
    endtask

    task automatic check_ack(input string tag, input bit ok, input int g, input int a, input int b);
        chk({tag, "_seen"}, ok, 1);
        chk({tag, "_ack"}, bus.ack, 1 << g);
        chk({tag, "_id"}, bus.result_id, g);
        chk({tag, "_result"}, bus.result, ref_prod(a, b));
        exp_ptr = (g + 1) % NREQ;
    endtask

    task automatic do_op(input int id, input int a, input int b, input string tag);
        bit ok;
        int lat, ldps, g, m;
        @(negedge clock);
        bus.op_a[id*W +: W] = W'(a);
        bus.op_b[id*W +: W] = W'(b);
        bus.req[id] = 1'b1;
        g = ref_pick(bus.req);
        m = ref_min(a, b);
        wait_ack(m + 20, ok, lat, ldps);
        bus.req[id] = 1'b0;
        check_ack(tag, ok, g, a, b);
        chk({tag, "_lat"}, lat, m + 4);
        chk({tag, "_ldp"}, ldps, m);
    endtask

    initial begin
        bit ok;
        int lat, ldps, g, prev_min;
        int ra[NREQ];
        int rb[NREQ];

        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_ptr = 0;

        chk("rst_strobes", strobes(), 0);
        chk("rst_bus", bus.dp_bus, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_id", bus.result_id, 0);

        do_op(0, 5, 3, "single");
        do_op(1, 3, 200, "swap");
        do_op(2, 0, 7, "zero_a");
        do_op(3, 9, 0, "zero_b");
        do_op(0, 300, 300, "wrap");
        chk("wrap_const", bus.result, 24464);

        for (int n = 0; n < 8; n++) begin
            do_op(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 30)), "rand");
        end

        // Round-robin with all requests held constant
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = int'($urandom_range(1, 1000));
            rb[i] = int'($urandom_range(1, 6));
            bus.op_a[i*W +: W] = W'(ra[i]);
            bus.op_b[i*W +: W] = W'(rb[i]);
        end
        bus.req = '1;
        prev_min = -1;
        for (int n = 0; n < 5; n++) begin
            g = ref_pick(bus.req);
            wait_ack(40, ok, lat, ldps);
            check_ack("rr", ok, g, ra[g], rb[g]);
            chk("rr_lat", lat, ref_min(ra[g], rb[g]) + ((prev_min < 0) ? 4 : 5));
            prev_min = ref_min(ra[g], rb[g]);
        end
        bus.req = '0;

        // Reset during ACC of 100x100
        @(negedge clock);
        bus.op_a[1*W +: W] = 16'd100;
        bus.op_b[1*W +: W] = 16'd100;
        bus.req[1] = 1'b1;
        repeat (10) @(negedge clock);
        chk("mid_ldp", bus.dp_ldp, 1);
        reset = 1'b1;
        bus.req = '0;
        @(negedge clock);
        reset = 1'b0;
        exp_ptr = 0;
        chk("mid_strobes", strobes(), 0);
        chk("mid_bus", bus.dp_bus, 0);
        chk("mid_result", bus.result, 0);
        chk("mid_valid", bus.result_valid, 0);

        // rr_ptr back at 0: req1 must win over req3
        bus.op_a[1*W +: W] = 16'd2;
        bus.op_b[1*W +: W] = 16'd3;
        bus.op_a[3*W +: W] = 16'd4;
        bus.op_b[3*W +: W] = 16'd5;
        bus.req = 4'b1010;
        g = ref_pick(bus.req);
        wait_ack(30, ok, lat, ldps);
        bus.req[1] = 1'b0;
        check_ack("ptr_first", ok, g, 2, 3);
        g = ref_pick(bus.req);
        wait_ack(30, ok, lat, ldps);
        bus.req[3] = 1'b0;
        check_ack("ptr_second", ok, g, 4, 5);
        chk("ptr_second_lat", lat, 4 + 5);

        do_op(2, 4, 4, "after_rst");

        // Operand change one cycle after grant
        @(negedge clock);
        bus.op_a[0*W +: W] = 16'd6;
        bus.op_b[0*W +: W] = 16'd7;
        bus.req[0] = 1'b1;
        g = ref_pick(bus.req);
        @(negedge clock);
        bus.op_a[0*W +: W] = 16'd50;
        bus.op_b[0*W +: W] = 16'd1;
        wait_ack(40, ok, lat, ldps);
        bus.req[0] = 1'b0;
        check_ack("late_op", ok, g, 6, 7);
        chk("late_op_lat", lat, 6 + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
